imm_instr_encoder: RTL and testbench
====================================

// Module: imm_instr_encoder
// PURPOSE
//  Inverse of the immediate generator: accepts a base instruction plus a 64-bit immediate,
//  range-checks the immediate and packs it into the RV64 instruction word. Encoded words
//  are queued in a 2-entry FIFO and streamed out with a word address for instruction-
//  memory preload by the test loader. Sits between the loader/assembler and instr memory.
// PARAMETERS
//  ADDR_W   32  width of emitted byte address; wraps modulo 2^ADDR_W
//  BASE_ADDR 0  address of first emitted word after reset
// PORTS
//  clk_i          in   1   clock, all logic on rising edge
//  rst_i          in   1   synchronous reset, active-high
//  in_valid_i     in   1   request valid
//  in_ready_o     out  1   request accepted when in_valid_i & in_ready_o
//  base_instr_i   in   32  opcode/rd/funct3/rs1/rs2 fields; immediate bit positions ignored
//  imm_i          in   64  two's-complement immediate
//  out_valid_o    out  1   FIFO head valid
//  out_ready_i    in   1   consumer takes head when out_valid_o & out_ready_i
//  instr_o        out  32  encoded instruction at FIFO head
//  addr_o         out  ADDR_W byte address of instr_o
//  err_o          out  1   one-cycle pulse: accepted request rejected
//  err_cnt_o      out  8   count of rejected requests, saturates at 255
// BEHAVIOUR
//  Reset: FIFO empty, out_valid_o=0, instr_o=0, addr_o=0, err_o=0, err_cnt_o=0,
//   in_ready_o=0 during reset cycle, write address counter=BASE_ADDR.
//  in_ready_o = (FIFO count < 2); combinational from registered count only.
//  Format from base_instr_i[6:0]: 0010011 -> I, 0100011 -> S, else unsupported.
//  Range: imm_i[63:11] must all equal imm_i[11] (12-bit signed), else reject.
//  I: instr[31:20]=imm[11:0]; S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0];
//   all other bits copied from base_instr_i.
//  Accepted+valid: push {instr, wr_addr} into FIFO in the same edge; out_valid_o high
//   next cycle (latency 1); wr_addr += 4, wrapping modulo 2^ADDR_W.
//  Accepted+rejected (range or opcode): no push, wr_addr unchanged, err_o=1 next cycle,
//   err_cnt_o+1 unless already 255.
//  Simultaneous push and pop: count unchanged; order strictly FIFO.
//  Full (count=2): in_ready_o=0; pop frees a slot, visible next cycle (no same-cycle pass).
//  Empty: out_valid_o=0; instr_o/addr_o hold last popped values.
//  Reset mid-stream: queued words discarded, address restarts at BASE_ADDR.
// CONFIGURATION
//  IMM_ENC_BTYPE_EN defined: opcode 1100011 -> B format; imm must be even and fit 13-bit
//   signed (imm[63:12] equal imm[12]); instr[31]=imm[12], [30:25]=imm[10:5],
//   [11:8]=imm[4:1], [7]=imm[11]. Odd or out-of-range -> reject.
//  Not defined: opcode 1100011 treated as unsupported -> reject.
// STRUCTURE
//  Shared package imm_enc_pkg: opcode constants OPC_ITYPE/OPC_STYPE/OPC_BTYPE, format
//   enum (FMT_I, FMT_S, FMT_B, FMT_BAD), range-check and packing functions.
//  Sub-module imm_enc_fifo: 2-entry synchronous FIFO, width 32+ADDR_W, count output.
//  Top: format decode, range check, pack, address counter, error counter.
// TESTING
//  I-type addi base 0x00000013, imm=-1 -> instr_o=0xFFF00013, addr_o=BASE_ADDR, 1-cycle latency.
//  S-type sd base 0x00003023, imm=0x7FF then imm=0x800 -> first 0x7E003FA3, second rejected,
//   err_o pulse, err_cnt_o=1, next good word gets BASE_ADDR+4.
//  out_ready_i=0, push 3 back-to-back -> in_ready_o low after 2; release -> order and
//   addresses BASE_ADDR, +4, +8 preserved; push+pop same cycle keeps count.
//  ADDR_W=4, BASE_ADDR=0xC: two pushes -> addr_o 0xC then 0x0 (wrap).
//  256 rejects, then 4 more -> err_cnt_o stays 255; rst_i with 2 queued -> out_valid_o=0.
//  B-type (macro on) imm=-4096 base 0x00000063 -> 0x80000063; imm=3 -> reject; macro off -> reject.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// imm_enc_pkg: opcodes, format enum, range-check and packing helpers for imm_instr_encoder
// Optional macro IMM_ENC_BTYPE_EN maps opcode 1100011 to the B format (default: unsupported).
package imm_enc_pkg;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_STYPE = 7'b0100011;
    localparam logic [6:0] OPC_BTYPE = 7'b1100011;

    typedef enum logic [1:0] {FMT_I, FMT_S, FMT_B, FMT_BAD} fmt_e;

    function automatic fmt_e decode_fmt(input logic [6:0] opc);
`ifdef IMM_ENC_BTYPE_EN
        return opc == OPC_ITYPE ? FMT_I : opc == OPC_STYPE ? FMT_S : opc == OPC_BTYPE ? FMT_B : FMT_BAD;
`else
        return opc == OPC_ITYPE ? FMT_I : opc == OPC_STYPE ? FMT_S : FMT_BAD;
`endif
    endfunction

    // Sign-extension test: every bit above the sign bit must replicate it.
    function automatic logic fits12(input logic [63:0] imm);
        return (&imm[63:11]) | ~(|imm[63:11]);
    endfunction

    function automatic logic fits13(input logic [63:0] imm);
        return (&imm[63:12]) | ~(|imm[63:12]);
    endfunction

    function automatic logic imm_ok(input fmt_e f, input logic [63:0] imm);
        return f == FMT_B ? fits13(imm) & ~imm[0] : f == FMT_BAD ? 1'b0 : fits12(imm);
    endfunction

    function automatic logic [31:0] pack(input fmt_e f, input logic [31:0] b, input logic [63:0] imm);
        return f == FMT_I ? {imm[11:0], b[19:0]} :
               f == FMT_S ? {imm[11:5], b[24:12], imm[4:0], b[6:0]} :
               f == FMT_B ? {imm[12], imm[10:5], b[24:12], imm[4:1], imm[11], b[6:0]} : b;
    endfunction
endpackage

// File: rtl/imm_enc_fifo.sv
// imm_enc_fifo: 2-entry synchronous FIFO whose output holds the last popped word when empty
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i write side, pop_i read side,
//        data_o head (or last popped word), count_o occupancy 0..2.
module imm_enc_fifo #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] last_q;
    logic         wp_q, rp_q;
    logic [1:0]   cnt_q, cnt_d;

    assign cnt_d   = cnt_q + 2'(push_i) - 2'(pop_i);
    assign count_o = cnt_q;
    assign data_o  = cnt_q != 2'd0 ? mem_q[rp_q] : last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            last_q   <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= data_i;
                wp_q        <= ~wp_q;
            end
            if (pop_i) begin
                last_q <= mem_q[rp_q];
                rp_q   <= ~rp_q;
            end
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: range-checks an immediate, packs it into an RV64 I/S(/B) word, queues it with its address
// Ports: clk_i, rst_i (sync, active-high); in_valid_i/in_ready_o, base_instr_i, imm_i request side;
//        out_valid_o/out_ready_i, instr_o, addr_o stream side; err_o reject pulse, err_cnt_o saturating count.
// Optional macro IMM_ENC_BTYPE_EN enables B-format encoding of opcode 1100011.
module imm_instr_encoder
    import imm_enc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       base_instr_i,
    input  logic [63:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o
);
    fmt_e              fmt;
    logic              ok, accept, push, rej, pop;
    logic [1:0]        count;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              err_q;

    assign fmt    = decode_fmt(base_instr_i[6:0]);
    assign ok     = imm_ok(fmt, imm_i);
    // Ready is held low while reset is asserted so no request is taken in that cycle.
    assign in_ready_o  = ~rst_i & (count < 2'd2);
    assign accept      = in_valid_i & in_ready_o;
    assign push        = accept & ok;
    assign rej         = accept & ~ok;
    assign out_valid_o = count != 2'd0;
    assign pop         = out_valid_o & out_ready_i;
    assign wr_addr_d   = push ? wr_addr_q + ADDR_W'(4) : wr_addr_q;
    assign err_cnt_d   = rej && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;

    imm_enc_fifo #(.W(32 + ADDR_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  ({pack(fmt, base_instr_i, imm_i), wr_addr_q}),
        .pop_i   (pop),
        .data_o  ({instr_o, addr_o}),
        .count_o (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_addr_q <= BASE_ADDR[ADDR_W-1:0];
            err_cnt_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= rej;
        end
    end
endmodule

// File: tb/tb_imm_instr_encoder.sv
// tb_imm_instr_encoder: directed self-checking bench for imm_instr_encoder
module tb_imm_instr_encoder;
    localparam logic [31:0] BA = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, err;
    logic [31:0] base, instr, addr;
    logic [63:0] imm;
    logic [7:0]  err_cnt;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, err2;
    logic [31:0] base2, instr2;
    logic [63:0] imm2;
    logic [3:0]  addr2;
    logic [7:0]  err_cnt2;

    int          tests = 0, fails = 0;
    logic [31:0] wa;
    int          ecnt;

    always #5 clk = ~clk;

    imm_instr_encoder #(.ADDR_W(32), .BASE_ADDR(64'(BA))) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .base_instr_i(base), .imm_i(imm), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .instr_o(instr), .addr_o(addr), .err_o(err), .err_cnt_o(err_cnt)
    );

    imm_instr_encoder #(.ADDR_W(4), .BASE_ADDR(64'hC)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .base_instr_i(base2), .imm_i(imm2), .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .instr_o(instr2), .addr_o(addr2), .err_o(err2), .err_cnt_o(err_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] b, input logic [63:0] v);
        in_valid = 1'b1;
        base = b;
        imm = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; base = '0; imm = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; base2 = '0; imm2 = '0;
        tick();
        tick();
        tests++; if (in_ready !== 1'b0) begin $display("FAIL rst_in_ready got %b want 0", in_ready); fails++; end
        tests++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid got %b want 0", out_valid); fails++; end
        tests++; if (instr !== 32'h0 || addr !== 32'h0) begin $display("FAIL rst_data got %h/%h want 0/0", instr, addr); fails++; end
        tests++; if (err !== 1'b0 || err_cnt !== 8'd0) begin $display("FAIL rst_err got %b/%0d want 0/0", err, err_cnt); fails++; end
        rst = 1'b0;
        tick();
        tests++; if (in_ready !== 1'b1) begin $display("FAIL rst_release_ready got %b want 1", in_ready); fails++; end
        wa = BA;
        ecnt = 0;
    endtask

    task automatic test_itype();
        send(32'h0000_0013, -64'sd1);
        tests++; if (out_valid !== 1'b1) begin $display("FAIL i_latency got %b want 1", out_valid); fails++; end
        tests++; if (instr !== 32'hFFF0_0013) begin $display("FAIL i_instr got %h want FFF00013", instr); fails++; end
        tests++; if (addr !== wa) begin $display("FAIL i_addr got %h want %h", addr, wa); fails++; end
        pop1();
        tests++; if (out_valid !== 1'b0 || instr !== 32'hFFF0_0013 || addr !== wa)
            begin $display("FAIL empty_hold got %b/%h/%h want 0/FFF00013/%h", out_valid, instr, addr, wa); fails++; end
        wa += 4;
    endtask

    task automatic test_stype();
        send(32'h0000_3023, 64'h7FF);
        tests++; if (instr !== 32'h7E00_3FA3 || addr !== wa) begin $display("FAIL s_instr got %h/%h want 7E003FA3/%h", instr, addr, wa); fails++; end
        wa += 4;
        out_ready = 1'b1;
        send(32'h0000_3023, 64'h800);
        out_ready = 1'b0;
        ecnt++;
        tests++; if (err !== 1'b1 || err_cnt !== 8'(ecnt)) begin $display("FAIL s_reject got %b/%0d want 1/%0d", err, err_cnt, ecnt); fails++; end
        tests++; if (out_valid !== 1'b0) begin $display("FAIL s_reject_nopush got %b want 0", out_valid); fails++; end
        tick();
        tests++; if (err !== 1'b0) begin $display("FAIL err_pulse got %b want 0", err); fails++; end
        send(32'h0000_0013, 64'd5);
        tests++; if (instr !== 32'h0050_0013 || addr !== wa) begin $display("FAIL s_next_addr got %h/%h want 00500013/%h", instr, addr, wa); fails++; end
        wa += 4;
        pop1();
    endtask

    task automatic test_range();
        send(32'h0000_0013, -64'sd2048);
        tests++; if (instr !== 32'h8000_0013 || addr !== wa) begin $display("FAIL i_min got %h/%h want 80000013/%h", instr, addr, wa); fails++; end
        wa += 4;
        pop1();
        send(32'h0000_0013, 64'h800);
        ecnt++;
        tests++; if (err !== 1'b1 || out_valid !== 1'b0) begin $display("FAIL i_over got %b/%b want 1/0", err, out_valid); fails++; end
        send(32'h0000_0013, 64'h1_0000_0000);
        ecnt++;
        tests++; if (err !== 1'b1 || out_valid !== 1'b0) begin $display("FAIL i_upper got %b/%b want 1/0", err, out_valid); fails++; end
        send(32'h0000_0033, 64'h0);
        ecnt++;
        tests++; if (err !== 1'b1 || err_cnt !== 8'(ecnt)) begin $display("FAIL bad_opc got %b/%0d want 1/%0d", err, err_cnt, ecnt); fails++; end
        send(32'h0000_0013, 64'd9);
        tests++; if (addr !== wa || instr !== 32'h0090_0013) begin $display("FAIL addr_after_rej got %h/%h want %h/00900013", addr, instr, wa); fails++; end
        wa += 4;
        pop1();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; base = 32'h0000_0013; imm = 64'd1;
        tick();
        tests++; if (in_ready !== 1'b1) begin $display("FAIL b2b_ready1 got %b want 1", in_ready); fails++; end
        imm = 64'd2;
        tick();
        tests++; if (in_ready !== 1'b0) begin $display("FAIL b2b_full got %b want 0", in_ready); fails++; end
        imm = 64'd3;
        tick();
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b0 || instr !== 32'h0010_0013 || addr !== wa)
            begin $display("FAIL b2b_head got %b/%h/%h want 0/00100013/%h", in_ready, instr, addr, wa); fails++; end
        out_ready = 1'b1;
        tick();
        tests++; if (instr !== 32'h0020_0013 || addr !== wa + 4 || in_ready !== 1'b1)
            begin $display("FAIL b2b_second got %h/%h/%b want 00200013/%h/1", instr, addr, in_ready, wa + 4); fails++; end
        in_valid = 1'b1; imm = 64'd3;
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || instr !== 32'h0030_0013 || addr !== wa + 8)
            begin $display("FAIL b2b_pushpop got %b/%b/%h/%h want 1/1/00300013/%h", out_valid, in_ready, instr, addr, wa + 8); fails++; end
        tick();
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || instr !== 32'h0030_0013) begin $display("FAIL b2b_drain got %b/%h want 0/00300013", out_valid, instr); fails++; end
        wa += 12;
    endtask

    task automatic test_wrap();
        in_valid2 = 1'b1; base2 = 32'h0000_0013; imm2 = 64'd1;
        tick();
        tests++; if (out_valid2 !== 1'b1 || addr2 !== 4'hC) begin $display("FAIL wrap_first got %b/%h want 1/c", out_valid2, addr2); fails++; end
        imm2 = 64'd2;
        tick();
        in_valid2 = 1'b0;
        out_ready2 = 1'b1;
        tick();
        tests++; if (addr2 !== 4'h0 || instr2 !== 32'h0020_0013) begin $display("FAIL wrap_second got %h/%h want 0/00200013", addr2, instr2); fails++; end
        tick();
        out_ready2 = 1'b0;
        tests++; if (out_valid2 !== 1'b0) begin $display("FAIL wrap_drain got %b want 0", out_valid2); fails++; end
    endtask

    task automatic test_err_sat();
        in_valid = 1'b1; base = 32'h0000_0033; imm = 64'h0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (ecnt < 255) ecnt++;
            if (ecnt == 254 && err_cnt !== 8'd254) begin
                $display("FAIL sat_254 got %0d want 254", err_cnt); fails++;
            end
        end
        tests++;
        tests++; if (err_cnt !== 8'd255) begin $display("FAIL sat_255 got %0d want 255", err_cnt); fails++; end
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        tests++; if (err_cnt !== 8'd255 || err !== 1'b1) begin $display("FAIL sat_hold got %0d/%b want 255/1", err_cnt, err); fails++; end
        tick();
        tests++; if (err !== 1'b0 || err_cnt !== 8'd255) begin $display("FAIL sat_idle got %b/%0d want 0/255", err, err_cnt); fails++; end
    endtask

    task automatic test_reset_mid();
        send(32'h0000_0013, 64'd1);
        send(32'h0000_0013, 64'd2);
        tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin $display("FAIL mid_full got %b/%b want 0/1", in_ready, out_valid); fails++; end
        rst = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || instr !== 32'h0 || err_cnt !== 8'd0)
            begin $display("FAIL mid_rst got %b/%b/%h/%0d want 0/0/0/0", out_valid, in_ready, instr, err_cnt); fails++; end
        rst = 1'b0;
        tick();
        wa = BA;
        ecnt = 0;
        send(32'h0000_0013, 64'd7);
        tests++; if (addr !== BA || instr !== 32'h0070_0013) begin $display("FAIL mid_restart got %h/%h want %h/00700013", addr, instr, BA); fails++; end
        wa += 4;
        pop1();
    endtask

    task automatic test_btype();
        send(32'h0000_0063, -64'sd4096);
`ifdef IMM_ENC_BTYPE_EN
        tests++; if (out_valid !== 1'b1 || instr !== 32'h8000_0063 || addr !== wa)
            begin $display("FAIL b_enc got %b/%h/%h want 1/80000063/%h", out_valid, instr, addr, wa); fails++; end
        wa += 4;
        pop1();
`else
        ecnt++;
        tests++; if (err !== 1'b1 || out_valid !== 1'b0 || err_cnt !== 8'(ecnt))
            begin $display("FAIL b_off got %b/%b/%0d want 1/0/%0d", err, out_valid, err_cnt, ecnt); fails++; end
`endif
        send(32'h0000_0063, 64'd3);
        ecnt++;
        tests++; if (err !== 1'b1 || out_valid !== 1'b0 || err_cnt !== 8'(ecnt))
            begin $display("FAIL b_odd got %b/%b/%0d want 1/0/%0d", err, out_valid, err_cnt, ecnt); fails++; end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_stype();
        test_range();
        test_back_to_back();
        test_wrap();
        test_err_sat();
        test_reset_mid();
        test_btype();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
